// File: rtl/div_pkg.sv
// ----------------------------------------------------------------------------
// div_pkg
// Shared definitions for the sequential divider: FSM state encoding, the
// default operand width and the iteration-counter width helper.
// No ports (package).
// ----------------------------------------------------------------------------
package div_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

    // Counter must index steps 0 .. width-1.
    function automatic int div_cnt_w(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

    localparam int DIV_CNT_W = div_cnt_w(DIV_WIDTH);

endpackage

// File: rtl/div_seq_ctrl_if.sv
// ----------------------------------------------------------------------------
// div_seq_ctrl_if
// Bundle between the ID/EXE pipeline side and the divide sequencer.
//   master (pipeline): drives start, is_sign, dividend, divisor, cancel,
//                      ex_stall; observes stall_req, busy, done, results.
//   slave  (divider):  the opposite directions.
// ----------------------------------------------------------------------------
interface div_seq_ctrl_if
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
);
    logic             start;
    logic             is_sign;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             cancel;
    logic             ex_stall;
    logic             stall_req;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_zero;

    modport master (
        output start, is_sign, dividend, divisor, cancel, ex_stall,
        input  stall_req, busy, done, quotient, remainder, div_zero
    );

    modport slave (
        input  start, is_sign, dividend, divisor, cancel, ex_stall,
        output stall_req, busy, done, quotient, remainder, div_zero
    );

endinterface

// File: rtl/div_iter_step.sv
// ----------------------------------------------------------------------------
// div_iter_step
// One combinational radix-2 restoring division step on magnitudes.
//   rem_in, quo_in : current partial remainder / quotient-dividend shift pair
//   divisor        : divisor magnitude
//   rem_out,quo_out: pair after shift-left and trial subtract
// ----------------------------------------------------------------------------
module div_iter_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic [WIDTH-1:0] quo_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic [WIDTH-1:0] quo_out
);

    logic [WIDTH:0]   rem_shift;
    logic [WIDTH+1:0] trial;
    logic             unused_trial_bit;

    always_comb begin
        rem_shift = {rem_in, quo_in[WIDTH-1]};
        // Extra top bit acts as the borrow of the WIDTH+1-bit subtraction.
        trial     = {1'b0, rem_shift} - {2'b00, divisor};
        if (!trial[WIDTH+1]) begin
            // A kept difference is always below the divisor, so it fits WIDTH bits.
            rem_out = trial[WIDTH-1:0];
            quo_out = {quo_in[WIDTH-2:0], 1'b1};
        end else begin
            rem_out = rem_shift[WIDTH-1:0];
            quo_out = {quo_in[WIDTH-2:0], 1'b0};
        end
    end

    assign unused_trial_bit = trial[WIDTH];

endmodule

// File: rtl/div_seq_ctrl.sv
// ----------------------------------------------------------------------------
// div_seq_ctrl
// Multi-cycle DIV/DIVU sequencer sitting behind the ID/EXE register.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : div_seq_ctrl_if.slave
//              in : start, is_sign, dividend, divisor, cancel, ex_stall
//              out: stall_req, busy, done, quotient, remainder, div_zero
// Flow: IDLE latches magnitudes and signs, CALC runs WIDTH restoring steps,
// FIX applies the signs, DONE presents the result until ex_stall drops.
// cancel wins over everything and never touches the result registers.
// ----------------------------------------------------------------------------
module div_seq_ctrl
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    div_seq_ctrl_if.slave bus
);

    localparam int CNT_W = div_cnt_w(WIDTH);

    div_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt;

    logic [WIDTH-1:0] rem_w, quo_w, dvsr;
    logic             q_neg, r_neg;
    logic [WIDTH-1:0] rem_step, quo_step;

    logic [WIDTH-1:0] quo_r, rem_r;
    logic             dz_r;

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_abs, b_abs;
    logic             accept, zero_div;

    always_comb begin
        a_neg    = bus.is_sign & bus.dividend[WIDTH-1];
        b_neg    = bus.is_sign & bus.divisor[WIDTH-1];
        // The most negative value maps to itself, which is its correct magnitude unsigned.
        a_abs    = a_neg ? -bus.dividend : bus.dividend;
        b_abs    = b_neg ? -bus.divisor  : bus.divisor;
        accept   = (state == IDLE) && bus.start && !bus.cancel;
        zero_div = (bus.divisor == '0);
    end

    div_iter_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem_w),
        .quo_in  (quo_w),
        .divisor (dvsr),
        .rem_out (rem_step),
        .quo_out (quo_step)
    );

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (bus.start) state_nxt = zero_div ? DONE : CALC;
            CALC:    if (cnt == CNT_W'(WIDTH - 1)) state_nxt = FIX;
            FIX:     state_nxt = DONE;
            DONE:    if (!bus.ex_stall) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (bus.cancel) state_nxt = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (accept) cnt <= '0;
            else if (state == CALC) cnt <= cnt + 1'b1;
        end
    end

    // Working registers: only meaningful between acceptance and FIX.
    always_ff @(posedge clk) begin
        if (accept) begin
            rem_w <= '0;
            quo_w <= a_abs;
            dvsr  <= b_abs;
            q_neg <= a_neg ^ b_neg;
            r_neg <= a_neg;
        end else if (state == CALC) begin
            rem_w <= rem_step;
            quo_w <= quo_step;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            quo_r <= '0;
            rem_r <= '0;
            dz_r  <= 1'b0;
        end else if (!bus.cancel) begin
            if (accept && zero_div) begin
                quo_r <= '1;
                rem_r <= bus.dividend;
                dz_r  <= 1'b1;
            end else if (state == FIX) begin
                quo_r <= q_neg ? -quo_w : quo_w;
                rem_r <= r_neg ? -rem_w : rem_w;
                dz_r  <= 1'b0;
            end
        end
    end

    // stall_req is combinational on start; gated by rst so reset reads all-zero.
    assign bus.stall_req = !rst && !bus.cancel &&
                           (((state == IDLE) && bus.start) || (state == CALC) || (state == FIX));
    assign bus.busy      = (state != IDLE);
    assign bus.done      = (state == DONE) && !bus.cancel;
    assign bus.quotient  = quo_r;
    assign bus.remainder = rem_r;
    assign bus.div_zero  = dz_r;

endmodule

// File: tb/tb_div_seq_ctrl.sv
module tb_div_seq_ctrl;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        int           first;
        int           len;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    bit   in_txn = 1'b0;
    int   left = 0;

    div_seq_ctrl_if #(.WIDTH(W)) bus ();

    div_seq_ctrl #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: plain integer division with the architectural rules.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                                  output logic [W-1:0] q, output logic [W-1:0] r, output logic dz);
        longint sa, sbv;
        dz = 1'b0;
        if (b == 0) begin
            q  = '1;
            r  = a;
            dz = 1'b1;
        end else if (!sgn) begin
            q = a / b;
            r = a % b;
        end else begin
            sa  = longint'($signed(a));
            sbv = longint'($signed(b));
            q   = W'(sa / sbv);
            r   = W'(sa % sbv);
        end
    endfunction

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.done) begin
                if (!in_txn) begin
                    if (sb.size() == 0) begin
                        check("unexpected_done", {63'd0, bus.done}, 64'd0);
                    end else begin
                        cur = sb.pop_front();
                        check("done_cycle", 64'(cyc), 64'(cur.first));
                        check("quotient", 64'(bus.quotient), 64'(cur.q));
                        check("remainder", 64'(bus.remainder), 64'(cur.r));
                        check("div_zero", 64'(bus.div_zero), 64'(cur.dz));
                        left   = cur.len - 1;
                        in_txn = 1'b1;
                    end
                end else begin
                    check("done_extra_cycle", 64'(left > 0), 64'd1);
                    check("quotient_hold", 64'(bus.quotient), 64'(cur.q));
                    check("remainder_hold", 64'(bus.remainder), 64'(cur.r));
                    left--;
                end
            end else begin
                if (in_txn) begin
                    check("done_len", 64'(left), 64'd0);
                    in_txn = 1'b0;
                end
                if (sb.size() > 0 && cyc > sb[0].first) begin
                    check("done_missing", 64'(cyc), 64'(sb[0].first));
                    void'(sb.pop_front());
                end
            end
        end
    end

    // One full divide; caller is just after a posedge with the DUT in IDLE.
    task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                          input int nstall);
        exp_t e;
        int   lat;
        bus.start    = 1'b1;
        bus.is_sign  = sgn;
        bus.dividend = a;
        bus.divisor  = b;
        bus.cancel   = 1'b0;
        bus.ex_stall = 1'b0;
        lat = (b == 0) ? 1 : W + 2;
        model(a, b, sgn, e.q, e.r, e.dz);
        e.first = cyc + lat;
        e.len   = nstall + 1;
        sb.push_back(e);
        for (int k = 0; k < lat; k++) begin
            @(negedge clk);
            check("stall_run", 64'(bus.stall_req), 64'd1);
            @(posedge clk); #1;
            if (k < lat - 1) begin
                bus.dividend = $urandom;
                bus.divisor  = $urandom;
                bus.ex_stall = 1'($urandom);
            end else begin
                bus.ex_stall = (nstall > 0);
            end
        end
        for (int j = 0; j <= nstall; j++) begin
            @(negedge clk);
            check("stall_done", 64'(bus.stall_req), 64'd0);
            @(posedge clk); #1;
            bus.ex_stall = (j + 1 < nstall);
        end
        bus.ex_stall = 1'b0;
        bus.start    = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.start = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("idle_busy", 64'(bus.busy), 64'd0);
            check("idle_stall", 64'(bus.stall_req), 64'd0);
            @(posedge clk); #1;
        end
    endtask

    function automatic logic [W-1:0] rand_operand();
        logic [W-1:0] v;
        case ($urandom_range(0, 3))
            0: v = W'($urandom_range(0, 200));
            1: v = $urandom;
            2: v = -W'($urandom_range(1, 200));
            default: begin
                case ($urandom_range(0, 3))
                    0: v = 32'h8000_0000;
                    1: v = 32'hFFFF_FFFF;
                    2: v = 32'd1;
                    default: v = 32'd0;
                endcase
            end
        endcase
        return v;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.is_sign  = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        bus.cancel   = 1'b0;
        bus.ex_stall = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_quotient", 64'(bus.quotient), 64'd0);
        check("rst_remainder", 64'(bus.remainder), 64'd0);
        check("rst_div_zero", 64'(bus.div_zero), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        idle(2);

        do_div(32'd100, 32'd7, 1'b0, 0);
        idle(1);
        do_div(32'hFFFF_FFF9, 32'd2, 1'b1, 0);
        do_div(32'hFFFF_FFF9, 32'd2, 1'b0, 0);
        do_div(32'd5, 32'd0, 1'b0, 0);
        idle(1);
        do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0);
        do_div(32'hFFFF_FC18, 32'd33, 1'b1, 3);
        idle(2);

        // Cancel mid-CALC, then a fresh divide two cycles later.
        t0 = cyc;
        bus.start    = 1'b1;
        bus.is_sign  = 1'b0;
        bus.dividend = 32'd12345;
        bus.divisor  = 32'd11;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("cancel_pre_stall", 64'(bus.stall_req), 64'd1);
            @(posedge clk); #1;
        end
        bus.cancel = 1'b1;
        @(negedge clk);
        check("cancel_stall", 64'(bus.stall_req), 64'd0);
        check("cancel_done", 64'(bus.done), 64'd0);
        @(posedge clk); #1;
        bus.cancel = 1'b0;
        bus.start  = 1'b0;
        @(negedge clk);
        check("cancel_idle", 64'(bus.busy), 64'd0);
        check("cancel_cycle", 64'(cyc), 64'(t0 + 11));
        @(posedge clk); #1;
        do_div(32'd1000, 32'd10, 1'b0, 0);
        idle(1);

        // Asynchronous reset in the middle of CALC.
        bus.start    = 1'b1;
        bus.dividend = 32'd999;
        bus.divisor  = 32'd4;
        repeat (6) begin
            @(posedge clk); #1;
        end
        #2 rst = 1'b1;
        #1;
        check("arst_busy", 64'(bus.busy), 64'd0);
        check("arst_done", 64'(bus.done), 64'd0);
        check("arst_stall", 64'(bus.stall_req), 64'd0);
        check("arst_quotient", 64'(bus.quotient), 64'd0);
        check("arst_remainder", 64'(bus.remainder), 64'd0);
        check("arst_div_zero", 64'(bus.div_zero), 64'd0);
        @(posedge clk); #1;
        bus.start = 1'b0;
        #2 rst = 1'b0;
        @(posedge clk); #1;
        idle(2);

        for (int n = 0; n < 40; n++) begin
            do_div(rand_operand(), rand_operand(), 1'($urandom), $urandom_range(0, 2));
            idle($urandom_range(0, 2));
        end

        idle(3);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        check("done_closed", 64'(in_txn), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/div_seq_ctrl.md
# div_seq_ctrl

Sequencer for the multi-cycle integer divider behind the ID/EXE register. It accepts a DIV/DIVU issued into EXE and runs a radix-2 restoring division over WIDTH cycles. While the division runs it raises a stall request that feeds the pipeline's stall0 path. It yields to interrupt and flush cancellation the same way the ID/EXE register does: cancel overrides stall.

## Interface
Parameters:
- WIDTH, 32, operand, quotient and remainder width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  ID/EXE is_div data; a divide is present in EXE.
- is_sign  in  1  ID/EXE is_sign_div data; 1 = DIV, 0 = DIVU.
- dividend  in  WIDTH  rs operand, forwarded.
- divisor  in  WIDTH  rt operand, forwarded.
- cancel  in  1  irq OR any clr; aborts the current operation.
- ex_stall  in  1  downstream stall; holds DONE.
- stall_req  out  1  stall request to the ID/EXE and upstream stages.
- busy  out  1  state is not IDLE.
- done  out  1  result valid; written to HI/LO this cycle.
- quotient  out  WIDTH  to LO.
- remainder  out  WIDTH  to HI.
- div_zero  out  1  divisor was 0 (informational, no exception).

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - On start && !cancel, latch |dividend|, |divisor|, the quotient sign (sign XOR, signed only) and the remainder sign (dividend sign, signed only). Clear the counter.
  - If divisor == 0, go to DONE with quotient = all ones, remainder = dividend, div_zero = 1.
  - Otherwise go to CALC.
- CALC, one step per cycle:
  - Shift {rem, quo} left by 1.
  - Trial subtract with WIDTH+1-bit arithmetic. If non-negative, keep the difference and set quo[0].
  - After WIDTH steps (counter = WIDTH-1), go to FIX.
- FIX:
  - Two's-complement negate the quotient if the quotient sign is set.
  - Negate the remainder if the remainder sign is set.
  - Go to DONE.
  - Signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 (wraps) and remainder 0.
- DONE:
  - Assert done and hold the outputs.
  - Stay in DONE while ex_stall = 1; otherwise go to IDLE.
- stall_req = !cancel && ((IDLE && start) || CALC || FIX).
- stall_req is low in DONE so ID/EXE loads the next instruction at the end of DONE.
- cancel in any state:
  - Next state is IDLE.
  - done and stall_req are forced 0 in the cancel cycle.
  - Result registers are not updated.
- Reset values:
  - State is IDLE.
  - quotient, remainder, div_zero, done, busy and stall_req are all 0.
  - Reset mid-operation discards the operation.

## Timing
- start seen at cycle T in IDLE.
- stall_req is combinational and is high from T through T+WIDTH+1.
- CALC spans T+1 .. T+WIDTH. FIX is at T+WIDTH+1. DONE is at T+WIDTH+2.
- With WIDTH = 32: 34 stall cycles, and done is high at T+34.
- Divide by zero: stall_req high only at T; done at T+1.
- done stays high for one cycle, plus one more cycle per cycle that ex_stall is held.
- A start present in the cycle after DONE is a new divide.
- Back-to-back divides have no bubble beyond the IDLE cycle.

## Structure
- Shared package div_pkg holds:
  - the state enum (IDLE, CALC, FIX, DONE);
  - the default WIDTH;
  - the counter width, clog2(WIDTH).
- Sub-module div_iter_step: a combinational single restoring step.
  - Inputs: {rem, quo} and divisor.
  - Outputs: next {rem, quo}.
- The FSM, counter, sign latches and FIX logic stay in div_seq_ctrl.

## Test plan
- Unsigned 100 / 7, start at T:
  - stall_req high T..T+33.
  - done at T+34 with quotient 14 and remainder 2.
- Signed −7 (0xFFFFFFF9) / 2:
  - quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
  - Unsigned same operands: quotient 0x7FFFFFFC, remainder 1.
- Divide by zero, 5 / 0:
  - done at T+1, div_zero = 1, quotient 0xFFFFFFFF, remainder 5.
  - stall_req high only at T.
- Signed 0x80000000 / 0xFFFFFFFF:
  - quotient 0x80000000, remainder 0, no error.
- cancel at T+10:
  - stall_req low at T+10; IDLE at T+11; done never asserted.
  - A new start at T+12 completes normally at T+46.
- ex_stall high for 3 cycles at DONE:
  - done and the results are held for 4 cycles.
  - No restart while start stays high.
- rst asserted mid-CALC:
  - All outputs read 0 asynchronously.
  - IDLE after release.
